// File: rtl/vga_timing_if.sv
// Raster timing bundle from vga_timing_gen to the sprite/background drawers.
// Optional frame counter signal present only when VGA_TIMING_FRAME_COUNT_EN is defined.
interface vga_timing_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        frame_start;
  logic        line_start;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] frame_cnt;
`endif

  modport master (
    output DrawX,
    output DrawY,
    output blank,
    output hs,
    output vs,
    output frame_start,
    output line_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    output frame_cnt
`endif
  );

  modport slave (
    input DrawX,
    input DrawY,
    input blank,
    input hs,
    input vs,
    input frame_start,
    input line_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel/line counters, blank, start pulses, delayed syncs.
// Optional: define VGA_TIMING_FRAME_COUNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic         vga_clk,
  input  logic         reset_n,
  vga_timing_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  if (SYNC_DELAY > 4) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be 0..4");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: counters are 10 bits wide");
  end

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       blank_q, blank_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       hs_int_q, hs_int_d;
  logic       vs_int_q, vs_int_d;

  // Qualifiers decode the next-state counters so they land in the same cycle as DrawX/DrawY.
  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
    end
    blank_d       = (hc_d < H_VIS) && (vc_d < V_VIS);
    hs_int_d      = !((hc_d >= H_SYNC_BEG) && (hc_d < H_SYNC_END));
    vs_int_d      = !((vc_d >= V_SYNC_BEG) && (vc_d < V_SYNC_END));
    line_start_d  = (hc_d == '0);
    frame_start_d = (hc_d == '0) && (vc_d == '0);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q          <= '0;
      vc_q          <= '0;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs_int_q      <= 1'b1;
      vs_int_q      <= 1'b1;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hs_int_q      <= hs_int_d;
      vs_int_q      <= vs_int_d;
    end
  end

  // Sync delay matches the drawers' ROM-read plus colour-register latency.
  if (SYNC_DELAY == 0) begin : g_no_delay
    assign vga.hs = hs_int_q;
    assign vga.vs = vs_int_q;
  end else begin : g_delay
    logic [1:0] sync_sr_q [SYNC_DELAY];

    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int unsigned k = 0; k < SYNC_DELAY; k++) begin
          sync_sr_q[k] <= '1;
        end
      end else begin
        sync_sr_q[0] <= {hs_int_q, vs_int_q};
        for (int unsigned k = 1; k < SYNC_DELAY; k++) begin
          sync_sr_q[k] <= sync_sr_q[k-1];
        end
      end
    end

    assign vga.hs = sync_sr_q[SYNC_DELAY-1][1];
    assign vga.vs = sync_sr_q[SYNC_DELAY-1][0];
  end

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

  assign vga.DrawX       = hc_q;
  assign vga.DrawY       = vc_q;
  assign vga.blank       = blank_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule
